// File: rtl/ripple_count_sampler.sv
// ============================================================================
// ripple_count_sampler : syncs/filters a 4-bit ripple count, extends it, snapshots
// Rev 1.0
// ============================================================================
`default_nettype none

module ripple_count_sampler #(
   parameter int STABLE_N = 2,
   parameter int EXT_W    = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [3:0]         cnt_in,
   input  logic               snap,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [EXT_W+3:0]   out_count,
   output logic [EXT_W+3:0]   cur_count,
   output logic               busy,
   output logic               ovf
);

   localparam logic [3:0] c_STAB_MAX = 4'(STABLE_N);
   localparam logic [3:0] c_STAB_THR = 4'(STABLE_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   logic [3:0]          s1_q, s2_q, s3_q;
   logic [3:0]          stab_q, stab_d;
   logic [3:0]          acc_q, acc_d;
   logic [EXT_W-1:0]    ext_q, ext_d;
   logic                ovf_q, ovf_d;
   state_t              state_q;
   logic                out_valid_q;
   logic [EXT_W+3:0]    out_count_q;

   logic                w_match;
   logic                w_stable;
   logic                w_accept;
   logic                w_wrap;

   always_comb begin
      w_match  = (s2_q == s3_q);
      w_stable = w_match && (stab_q >= c_STAB_THR);
      w_accept = w_stable && (s2_q != acc_q);
      // A numerically smaller accepted value means the source passed 15->0.
      w_wrap   = w_accept && (s2_q < acc_q);

      stab_d = stab_q;
      if (!w_match) begin
         stab_d = 4'd0;
      end else if (stab_q < c_STAB_MAX) begin
         stab_d = stab_q + 4'd1;
      end

      acc_d = w_accept ? s2_q : acc_q;

      ext_d = ext_q;
      ovf_d = ovf_q;
      if (w_wrap) begin
         ext_d = ext_q + EXT_W'(1);
         if (&ext_q) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         s1_q        <= 4'd0;
         s2_q        <= 4'd0;
         s3_q        <= 4'd0;
         stab_q      <= 4'd0;
         acc_q       <= 4'd0;
         ext_q       <= '0;
         ovf_q       <= 1'b0;
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
      end else begin
         s1_q   <= cnt_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         stab_q <= stab_d;
         acc_q  <= acc_d;
         ext_q  <= ext_d;
         ovf_q  <= ovf_d;

         case (state_q)
            ST_IDLE: begin
               if (snap) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Capture only a settled value that is already the accepted one.
               if (w_stable && (s2_q == acc_q)) begin
                  out_count_q <= {ext_q, acc_q};
                  out_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign cur_count = {ext_q, acc_q};
   assign busy      = (state_q != ST_IDLE);
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
// ============================================================================
// tb_ripple_count_sampler : directed scenarios plus random traffic vs a count model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ripple_count_sampler;

   localparam int STABLE_N = 2;
   localparam int EXT_W    = 4;

   logic             clk;
   logic             clr;
   logic [3:0]       cnt_in;
   logic             snap;
   logic             out_ready;
   logic             out_valid;
   logic [EXT_W+3:0] out_count;
   logic [EXT_W+3:0] cur_count;
   logic             busy;
   logic             ovf;

   int n_vec = 0;
   int n_bad = 0;

   ripple_count_sampler #(.STABLE_N(STABLE_N), .EXT_W(EXT_W)) dut (
      .clk       (clk),
      .clr       (clr),
      .cnt_in    (cnt_in),
      .snap      (snap),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_count (out_count),
      .cur_count (cur_count),
      .busy      (busy),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the filter view is the input two samples back; a value is
   // trusted once that view held across STABLE_N+1 consecutive views since clear.
   // The running count advances by the forward mod-16 distance of each accept.
   int   m_hist[$];
   int   m_nsamp;
   longint m_total;
   int   m_mode;     // 0 idle, 1 waiting, 2 holding
   int   m_out;
   bit   m_valid;
   bit   m_init = 1'b0;
   bit   m_stable;
   int   m_view, m_acc;
   logic i_clr, i_snap, i_rdy;
   int   i_cnt;

   function automatic int hv(int j);
      return (j < m_hist.size()) ? m_hist[j] : 0;
   endfunction

   always @(posedge clk) begin
      i_clr  = clr;
      i_cnt  = int'(cnt_in);
      i_snap = snap;
      i_rdy  = out_ready;
      if (i_clr) begin
         m_hist.delete();
         m_nsamp = 0;
         m_total = 0;
         m_mode  = 0;
         m_out   = 0;
         m_valid = 1'b0;
         m_init  = 1'b1;
      end else if (m_init) begin
         m_stable = 1'b1;
         for (int j = 0; j < STABLE_N; j++)
            if (j > m_nsamp || hv(1 + j) != hv(2 + j)) m_stable = 1'b0;
         m_view = hv(1);
         m_acc  = int'(m_total % 16);
         case (m_mode)
            0: if (i_snap) m_mode = 1;
            1: if (m_stable && m_view == m_acc) begin
                  m_out   = int'(m_total % 256);
                  m_valid = 1'b1;
                  m_mode  = 2;
               end
            default: if (i_rdy) begin
                  m_valid = 1'b0;
                  m_mode  = 0;
               end
         endcase
         if (m_stable && m_view != m_acc) m_total += (m_view - m_acc + 16) % 16;
         m_hist.push_front(i_cnt);
         if (m_hist.size() > 40) void'(m_hist.pop_back());
         m_nsamp++;
      end
      #1;
      if (m_init) begin
         chk("cyc_out_valid", out_valid, m_valid);
         chk("cyc_out_count", out_count, m_out);
         chk("cyc_cur_count", cur_count, 32'(m_total % 256));
         chk("cyc_busy",      busy,      m_mode != 0);
         chk("cyc_ovf",       ovf,       m_total >= 256);
      end
   end

   task automatic hold(input int v, input int n);
      cnt_in = 4'(v);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clr(input int v);
      clr    = 1'b1;
      cnt_in = 4'(v);
      @(negedge clk);
      clr = 1'b0;
   endtask

   int base;
   int hold_left;

   initial begin
      clr = 1'b1; cnt_in = 4'd5; snap = 1'b0; out_ready = 1'b0;

      // Reset and first snapshot
      @(negedge clk); @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_count", out_count, 0);
      chk("rst_cur",   cur_count, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_ovf",   ovf, 0);
      clr = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_edge4_cur", cur_count, 0);
      @(negedge clk);
      chk("rst_edge5_cur", cur_count, 8'h05);
      snap = 1'b1; @(negedge clk); snap = 1'b0;
      chk("snap_wait_busy",  busy, 1);
      chk("snap_wait_valid", out_valid, 0);
      @(negedge clk);
      chk("snap_valid", out_valid, 1);
      chk("snap_count", out_count, 8'h05);
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
      chk("snap_done_valid", out_valid, 0);
      chk("snap_done_busy",  busy, 0);

      // Latency and single-period glitch
      do_clr(0);
      hold(3, 8);
      chk("glitch_pre", cur_count, 8'h03);
      cnt_in = 4'd7; @(negedge clk);
      cnt_in = 4'd4;
      repeat (4) @(negedge clk);
      chk("glitch_edge4", cur_count, 8'h03);
      @(negedge clk);
      chk("glitch_edge5", cur_count, 8'h04);
      hold(4, 3);

      // Wrap extension
      hold(14, 8); chk("wrap_0e", cur_count, 8'h0E);
      hold(15, 8); chk("wrap_0f", cur_count, 8'h0F);
      hold(0, 8);  chk("wrap_10", cur_count, 8'h10);
      hold(1, 8);  chk("wrap_11", cur_count, 8'h11);
      chk("wrap_ovf", ovf, 0);

      // Overflow of the extension
      do_clr(0);
      for (int i = 1; i < 256; i++) hold(i % 16, 8);
      chk("ovf_ff_cur", cur_count, 8'hFF);
      chk("ovf_ff_flag", ovf, 0);
      hold(0, 8);
      chk("ovf_00_cur", cur_count, 8'h00);
      chk("ovf_00_flag", ovf, 1);
      for (int i = 1; i < 6; i++) hold(i, 8);
      chk("ovf_sticky", ovf, 1);
      do_clr(0);
      chk("ovf_clr", ovf, 0);

      // Backpressure
      for (int i = 1; i <= 35; i++) hold(i % 16, 6);
      chk("bp_cur", cur_count, 8'h23);
      snap = 1'b1; @(negedge clk); snap = 1'b0; @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_count", out_count, 8'h23);
      for (int k = 0; k < 10; k++) begin
         cnt_in = 4'((4 + k / 2) % 16);
         snap   = (k % 3 == 0);
         @(negedge clk);
         chk("bp_hold_count", out_count, 8'h23);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_busy",  busy, 1);
      end
      snap = 1'b0; out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
      chk("bp_xfer_valid", out_valid, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_noqueue_busy",  busy, 0);
         chk("bp_noqueue_valid", out_valid, 0);
      end

      // Clear during WAIT and during HOLD
      do_clr(0);
      hold(2, 8);
      cnt_in = 4'd5; @(negedge clk);
      cnt_in = 4'd9; @(negedge clk);
      cnt_in = 4'd12; snap = 1'b1; @(negedge clk); snap = 1'b0;
      chk("mid_wait_busy",  busy, 1);
      chk("mid_wait_valid", out_valid, 0);
      do_clr(1);
      chk("mid_wait_clr_busy",  busy, 0);
      chk("mid_wait_clr_valid", out_valid, 0);
      chk("mid_wait_clr_cur",   cur_count, 0);
      hold(6, 8);
      snap = 1'b1; @(negedge clk); snap = 1'b0; @(negedge clk);
      chk("mid_hold_valid", out_valid, 1);
      do_clr(6);
      chk("mid_hold_clr_busy",  busy, 0);
      chk("mid_hold_clr_valid", out_valid, 0);
      chk("mid_hold_clr_cur",   cur_count, 0);

      // Random traffic against the model
      base = 6; hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         clr       = ($urandom % 300 == 0);
         snap      = ($urandom % 6 == 0);
         out_ready = ($urandom % 3 == 0);
         if (hold_left == 0) begin
            if ($urandom % 5 == 0) begin
               cnt_in    = 4'($urandom % 16);
               hold_left = 1;
            end else begin
               base      = (base + int'($urandom_range(1, 3))) % 16;
               cnt_in    = 4'(base);
               hold_left = int'($urandom_range(1, 7));
            end
         end
         hold_left--;
         @(negedge clk);
      end
      clr = 1'b0; snap = 1'b0; out_ready = 1'b0;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
